dfi_init_ctrl: RTL and testbench

// TL-UL device-port slave that sequences the DFI memory-training handshake of the DDR PHY.

---
 rtl/dfi_init_ctrl_pkg.sv | 33 +++
 rtl/dfi_init_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_dfi_init_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dfi_init_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dfi_init_ctrl_pkg
// TL-UL channel structures shared by dfi_init_ctrl and its environment.
//   tl_h2d_t : A channel request plus D-channel ready (host -> device)
//   tl_d2h_t : D channel response plus A-channel ready (device -> host)
// -----------------------------------------------------------------------------
package dfi_init_ctrl_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/dfi_init_ctrl.sv
// -----------------------------------------------------------------------------
// dfi_init_ctrl
// TL-UL register slave that sequences the DFI init/training handshake with the
// DDR PHY: raises dfi_init_start_o, waits for dfi_init_done_i, enforces a
// programmable timeout and reports status, last latency and a level interrupt.
// Ports:
//   clk_i            system clock
//   rst_ni           synchronous active-low reset
//   tl_i / tl_o      TL-UL device port (one outstanding request)
//   dfi_init_start_o registered start request, high only in WAIT_DONE
//   dfi_init_done_i  training complete level from the PHY
//   intr_o           registered (DONE | TIMEOUT) & IE
// Register map (word offsets from a_address[3:2]):
//   0x0 CTRL    [0] START (W1, reads 0) [1] ABORT (W1, reads 0) [2] AUTO_EN [3] IE
//   0x4 STATUS  RO [0] BUSY [1] DONE [2] TIMEOUT [3] raw done [6:4] state
//   0x8 TIMEOUT RW cycle limit, 0 disables
//   0xC COUNT   RO WAIT_DONE cycles of the last completed training
// -----------------------------------------------------------------------------
module dfi_init_ctrl
    import dfi_init_ctrl_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic        AUTO_START     = 1'b1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    dfi_init_start_o,
    input  logic    dfi_init_done_i,
    output logic    intr_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOW  = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_DONE      = 3'd3,
        ST_TO        = 3'd4
    } state_e;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // Byte-lane merge of a masked write into an existing register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    state_e      r_state, w_state_nxt;
    logic        r_first;            // high only in the first cycle after reset
    logic        r_auto_en, r_ie, r_done, r_to, r_start, r_intr;
    logic [31:0] r_timeout, r_count, r_counter;
    logic        w_auto_en_nxt, w_ie_nxt, w_done_nxt, w_to_nxt;
    logic [31:0] w_timeout_nxt, w_count_nxt, w_counter_nxt;

    logic        r_d_valid, r_d_error;
    logic [2:0]  r_d_opcode;
    logic [1:0]  r_d_size;
    logic [7:0]  r_d_source;
    logic [31:0] r_d_data;

    logic        w_a_fire, w_is_get, w_is_put, w_req_err, w_wr;
    logic        w_ctrl_wr, w_start_cmd, w_abort_cmd, w_busy;
    logic [1:0]  w_offset;
    logic [31:0] w_rdata, w_status;
    logic        w_unused;

    assign w_unused    = ^{tl_i.a_param, tl_i.a_address[31:4]};

    assign w_a_fire    = tl_i.a_valid & ~r_d_valid;
    assign w_offset    = tl_i.a_address[3:2];
    assign w_is_get    = (tl_i.a_opcode == OP_GET);
    assign w_is_put    = (tl_i.a_opcode == OP_PUT_FULL) | (tl_i.a_opcode == OP_PUT_PARTIAL);
    // Errors: unknown opcode, sub-word address, or a write to a read-only register.
    assign w_req_err   = (~w_is_get & ~w_is_put)
                       | (tl_i.a_address[1:0] != 2'b00)
                       | (w_is_put & ((w_offset == 2'd1) | (w_offset == 2'd3)));
    assign w_wr        = w_a_fire & w_is_put & ~w_req_err;
    assign w_ctrl_wr   = w_wr & (w_offset == 2'd0) & tl_i.a_mask[0];
    // ABORT takes precedence when both command bits are written together.
    assign w_abort_cmd = w_ctrl_wr & tl_i.a_data[1];
    assign w_start_cmd = w_ctrl_wr & tl_i.a_data[0] & ~tl_i.a_data[1];
    assign w_busy      = (r_state == ST_WAIT_LOW) | (r_state == ST_WAIT_DONE);
    assign w_status    = {25'd0, r_state, dfi_init_done_i, r_to, r_done, w_busy};

    // Register read multiplexer.
    always_comb begin
        w_rdata = 32'd0;
        case (w_offset)
            2'd0:    w_rdata = {28'd0, r_ie, r_auto_en, 2'b00};
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = r_timeout;
            2'd3:    w_rdata = r_count;
            default: w_rdata = 32'd0;
        endcase
    end

    // Next-state, register-write and training-sequencer logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_done_nxt    = r_done;
        w_to_nxt      = r_to;
        w_count_nxt   = r_count;
        w_counter_nxt = 32'd0;       // only WAIT_DONE keeps counting
        w_auto_en_nxt = r_auto_en;
        w_ie_nxt      = r_ie;
        w_timeout_nxt = r_timeout;

        if (w_ctrl_wr) begin
            w_auto_en_nxt = tl_i.a_data[2];
            w_ie_nxt      = tl_i.a_data[3];
        end else begin
            w_auto_en_nxt = r_auto_en;
        end

        if (w_wr & (w_offset == 2'd2)) begin
            w_timeout_nxt = merge_bytes(r_timeout, tl_i.a_data, tl_i.a_mask);
        end else begin
            w_timeout_nxt = r_timeout;
        end

        if (w_abort_cmd) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b0;
            w_to_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_first & r_auto_en) | w_start_cmd) begin
                        w_state_nxt = ST_WAIT_LOW;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    // A done level left over from a previous run must drop first.
                    if (!dfi_init_done_i) begin
                        w_state_nxt = ST_WAIT_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT_LOW;
                    end
                end
                ST_WAIT_DONE: begin
                    w_counter_nxt = (r_counter == 32'hFFFF_FFFF) ? r_counter : r_counter + 32'd1;
                    if (dfi_init_done_i) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_count_nxt = r_counter;
                    end else if ((r_timeout != 32'd0) && (r_counter == r_timeout - 32'd1)) begin
                        w_state_nxt = ST_TO;
                        w_to_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_DONE;
                    end
                end
                ST_DONE, ST_TO: begin
                    if (w_start_cmd) begin
                        w_state_nxt = ST_WAIT_LOW;
                        w_done_nxt  = 1'b0;
                        w_to_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Control/status state, registered start and interrupt outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_first   <= 1'b1;
            r_auto_en <= AUTO_START;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
            r_to      <= 1'b0;
            r_timeout <= TIMEOUT_CYCLES;
            r_count   <= 32'd0;
            r_counter <= 32'd0;
            r_start   <= 1'b0;
            r_intr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_first   <= 1'b0;
            r_auto_en <= w_auto_en_nxt;
            r_ie      <= w_ie_nxt;
            r_done    <= w_done_nxt;
            r_to      <= w_to_nxt;
            r_timeout <= w_timeout_nxt;
            r_count   <= w_count_nxt;
            r_counter <= w_counter_nxt;
            // Registered from next state so start is high exactly while in WAIT_DONE.
            r_start   <= (w_state_nxt == ST_WAIT_DONE);
            r_intr    <= w_ie_nxt & (w_done_nxt | w_to_nxt);
        end
    end

    // TL-UL response channel: captured on request acceptance, held until d_ready.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_d_valid  <= 1'b0;
            r_d_error  <= 1'b0;
            r_d_opcode <= 3'd0;
            r_d_size   <= 2'd0;
            r_d_source <= 8'd0;
            r_d_data   <= 32'd0;
        end else if (w_a_fire) begin
            r_d_valid  <= 1'b1;
            r_d_error  <= w_req_err;
            r_d_opcode <= w_is_get ? OP_ACK_DATA : OP_ACK;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_data   <= (w_is_get & ~w_req_err) ? w_rdata : 32'd0;
        end else if (tl_i.d_ready) begin
            r_d_valid  <= 1'b0;
        end else begin
            r_d_valid  <= r_d_valid;
        end
    end

    assign tl_o = '{
        d_valid:  r_d_valid,
        d_opcode: r_d_opcode,
        d_param:  3'd0,
        d_size:   r_d_size,
        d_source: r_d_source,
        d_sink:   1'b0,
        d_data:   r_d_data,
        d_error:  r_d_error,
        a_ready:  ~r_d_valid
    };

    assign dfi_init_start_o = r_start;
    assign intr_o           = r_intr;

endmodule

// File: tb/tb_dfi_init_ctrl.sv
`timescale 1ns/1ps
module tb_dfi_init_ctrl;
    import dfi_init_ctrl_pkg::*;

    localparam logic [31:0] TO_RST   = 32'd1_000_000;
    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_TMO    = 32'h8;
    localparam logic [31:0] A_COUNT  = 32'hC;
    localparam logic [2:0]  S_IDLE = 3'd0, S_WLOW = 3'd1, S_WDONE = 3'd2, S_DONE = 3'd3, S_TO = 3'd4;

    typedef struct packed {
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
        logic [7:0]  src;
        logic [1:0]  size;
    } rsp_t;

    logic    clk = 1'b0;
    logic    rst_ni = 1'b0;
    logic    done_i = 1'b0;
    logic    d_ready = 1'b0;
    tl_h2d_t req;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic    start_o, intr_o;

    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    int   stall_req = 0;

    // bench model of software-visible state
    logic        m_auto = 1'b1;
    logic        m_ie = 1'b0;
    logic [31:0] m_count = 32'd0;

    always #5 clk = ~clk;

    always_comb begin
        tl_i = req;
        tl_i.d_ready = d_ready;
    end

    dfi_init_ctrl #(.TIMEOUT_CYCLES(TO_RST), .AUTO_START(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o),
        .dfi_init_start_o(start_o), .dfi_init_done_i(done_i), .intr_o(intr_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic busy, input logic dn, input logic to,
                                       input logic raw, input logic [2:0] s);
        return {25'd0, s, raw, to, dn, busy};
    endfunction

    function automatic logic [31:0] ctrl(input logic start, input logic abort);
        return {28'd0, m_ie, m_auto, abort, start};
    endfunction

    // response monitor: random backpressure, pops the scoreboard on each handshake
    initial begin : monitor
        rsp_t cur, held, e;
        logic holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                d_ready = 1'b0;
                holding = 1'b0;
                continue;
            end
            check("a_ready", tl_o.a_ready, !tl_o.d_valid);
            if (tl_o.d_valid) begin
                cur = {tl_o.d_opcode, tl_o.d_error, tl_o.d_data, tl_o.d_source, tl_o.d_size};
                if (holding) check("d_stable", cur, held);
                holding = 1'b1;
                held = cur;
                if (stall_req > 0) begin
                    stall_req--;
                    d_ready = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    d_ready = 1'b0;
                end else begin
                    d_ready = 1'b1;
                    holding = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("tl_rsp", cur, e);
                    end
                end
            end else begin
                holding = 1'b0;
                d_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tl_o.d_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic tl_xfer(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_data,
                           input bit do_drain);
        rsp_t e;
        int   n;
        n = 0;
        while (!tl_o.a_ready && n < 50) begin
            tick();
            n++;
        end
        if (!tl_o.a_ready) begin
            checks++;
            failures++;
            $display("FAIL a_ready_timeout: got 0 expected 1");
        end
        req.a_valid   = 1'b1;
        req.a_opcode  = op;
        req.a_param   = 3'd0;
        req.a_size    = 2'd2;
        req.a_source  = 8'($urandom_range(0, 255));
        req.a_address = addr;
        req.a_mask    = mask;
        req.a_data    = wdata;
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.err  = exp_err;
        e.data = (exp_err || op != 3'd4) ? 32'd0 : exp_data;
        e.src  = req.a_source;
        e.size = 2'd2;
        exp_q.push_back(e);
        tick();
        req.a_valid = 1'b0;
        if (do_drain) drain();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        tl_xfer(3'd4, addr, 4'hF, 32'd0, 1'b0, exp, 1'b1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        tl_xfer(3'd0, addr, 4'hF, data, 1'b0, 32'd0, 1'b1);
    endtask

    // waits for start_o, then counts its high cycles; done_i raised when d cycles have elapsed in WAIT_DONE
    task automatic run_measure(input int d, input int limit, output int high, output int waited);
        high = 0;
        waited = 0;
        while (!start_o && waited < 8) begin
            tick();
            waited++;
        end
        if (start_o) begin
            high = 1;
            for (int k = 0; k < limit; k++) begin
                if (k == d) done_i = 1'b1;
                tick();
                if (!start_o) break;
                high++;
            end
        end
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  high, waited, t, d, n_hi;
        logic ie, exp_to;
        logic [31:0] old_v, new_v, merged;
        logic [3:0]  pmask;
        req = '0;
        repeat (3) tick();
        check("rst_start", start_o, 1'b0);
        check("rst_intr", intr_o, 1'b0);
        check("rst_dvalid", tl_o.d_valid, 1'b0);
        check("rst_aready", tl_o.a_ready, 1'b1);

        // auto start after reset, done 50 cycles into WAIT_DONE
        rst_ni = 1'b1;
        run_measure(50, 200, high, waited);
        check("auto_latency_le3", waited <= 3, 1'b1);
        check("auto_start_high", high, 51);
        check("done_intr_ie0", intr_o, 1'b0);
        m_count = 32'd50;
        rd(A_STATUS, st(1'b0, 1'b1, 1'b0, 1'b1, S_DONE));
        rd(A_COUNT, 32'd50);
        rd(A_TMO, TO_RST);
        rd(A_CTRL, 32'h4);
        m_ie = 1'b1;
        wr(A_CTRL, ctrl(1'b0, 1'b0));
        check("intr_ie1", intr_o, 1'b1);
        rd(A_CTRL, 32'hC);
        m_ie = 1'b0;
        wr(A_CTRL, ctrl(1'b0, 1'b0));
        check("intr_ie0", intr_o, 1'b0);
        done_i = 1'b0;

        // timeout of 100 cycles
        wr(A_TMO, 32'd100);
        tl_xfer(3'd0, A_CTRL, 4'hF, ctrl(1'b1, 1'b0), 1'b0, 32'd0, 1'b0);
        run_measure(100000, 300, high, waited);
        check("to100_high", high, 100);
        rd(A_STATUS, st(1'b0, 1'b0, 1'b1, 1'b0, S_TO));
        rd(A_COUNT, m_count);

        // randomized runs, including done on the timeout cycle and done one cycle late
        for (int it = 0; it < 10; it++) begin
            if (it == 0) begin t = 30; d = 29; end
            else if (it == 1) begin t = 30; d = 30; end
            else if (it == 2) begin t = 0; d = $urandom_range(0, 40); end
            else begin t = $urandom_range(2, 60); d = $urandom_range(0, t + 10); end
            ie = 1'($urandom_range(0, 1));
            done_i = 1'b0;
            wr(A_TMO, t);
            m_ie = ie;
            tl_xfer(3'd0, A_CTRL, 4'hF, ctrl(1'b1, 1'b0), 1'b0, 32'd0, 1'b0);
            run_measure(d, t + d + 20, high, waited);
            exp_to = (t != 0) && (d >= t);
            check("rand_high", high, exp_to ? t : d + 1);
            if (!exp_to) m_count = d;
            check("rand_intr", intr_o, ie);
            drain();
            rd(A_STATUS, st(1'b0, !exp_to, exp_to, done_i, exp_to ? S_TO : S_DONE));
            rd(A_COUNT, m_count);
            done_i = 1'b0;
        end

        // stale done holds WAIT_LOW; START while busy ignored; ABORT
        m_ie = 1'b0;
        wr(A_TMO, 32'd0);
        done_i = 1'b1;
        tl_xfer(3'd0, A_CTRL, 4'hF, ctrl(1'b1, 1'b0), 1'b0, 32'd0, 1'b0);
        n_hi = 0;
        repeat (5) begin
            tick();
            if (start_o) n_hi++;
        end
        check("waitlow_start", n_hi, 0);
        rd(A_STATUS, st(1'b1, 1'b0, 1'b0, 1'b1, S_WLOW));
        done_i = 1'b0;
        waited = 0;
        while (!start_o && waited < 4) begin
            tick();
            waited++;
        end
        check("waitlow_release", start_o, 1'b1);
        wr(A_CTRL, ctrl(1'b1, 1'b0));
        check("start_busy_ignored", start_o, 1'b1);
        rd(A_STATUS, st(1'b1, 1'b0, 1'b0, 1'b0, S_WDONE));
        tl_xfer(3'd0, A_CTRL, 4'hF, ctrl(1'b0, 1'b1), 1'b0, 32'd0, 1'b0);
        check("abort_start", start_o, 1'b0);
        drain();
        rd(A_STATUS, st(1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));
        rd(A_COUNT, m_count);
        wr(A_CTRL, ctrl(1'b1, 1'b1));
        n_hi = 0;
        repeat (4) begin
            tick();
            if (start_o) n_hi++;
        end
        check("start_abort_idle", n_hi, 0);
        rd(A_STATUS, st(1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));

        // TL-UL backpressure and error responses
        stall_req = 5;
        rd(A_STATUS, st(1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));
        tl_xfer(3'd3, A_CTRL, 4'hF, 32'h1, 1'b1, 32'd0, 1'b1);
        repeat (3) tick();
        check("badop_no_start", start_o, 1'b0);
        tl_xfer(3'd0, A_STATUS, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1);
        rd(A_STATUS, st(1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));
        tl_xfer(3'd0, A_COUNT, 4'hF, 32'h1234_5678, 1'b1, 32'd0, 1'b1);
        rd(A_COUNT, m_count);
        tl_xfer(3'd4, 32'h6, 4'hF, 32'd0, 1'b1, 32'd0, 1'b1);
        old_v = 32'h1122_3344;
        wr(A_TMO, old_v);
        tl_xfer(3'd0, 32'h9, 4'hF, 32'h0, 1'b1, 32'd0, 1'b1);
        rd(A_TMO, old_v);
        new_v = $urandom();
        pmask = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) merged[b*8 +: 8] = pmask[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        tl_xfer(3'd1, A_TMO, pmask, new_v, 1'b0, 32'd0, 1'b1);
        rd(A_TMO, merged);

        // synchronous reset in the middle of WAIT_DONE
        wr(A_TMO, 32'd0);
        m_ie = 1'b1;
        tl_xfer(3'd0, A_CTRL, 4'hF, ctrl(1'b1, 1'b0), 1'b0, 32'd0, 1'b0);
        waited = 0;
        while (!start_o && waited < 8) begin
            tick();
            waited++;
        end
        check("pre_rst_start", start_o, 1'b1);
        drain();
        rst_ni = 1'b0;
        tick();
        check("mid_rst_start", start_o, 1'b0);
        check("mid_rst_intr", intr_o, 1'b0);
        check("mid_rst_dvalid", tl_o.d_valid, 1'b0);
        check("mid_rst_aready", tl_o.a_ready, 1'b1);
        tick();
        rst_ni = 1'b1;
        m_ie = 1'b0;
        rd(A_TMO, TO_RST);
        rd(A_CTRL, 32'h4);
        rd(A_COUNT, 32'd0);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
